// File: rtl/axis_bram_reader.sv
// Streams a window of the capture BRAM out as AXI-Stream, with circular addressing,
// a 2-entry output FIFO and read-credit flow control so no word is ever dropped.
module axis_bram_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 16,
  parameter int BRAM_ADDR_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 rd_control,
  input  logic [BRAM_ADDR_WIDTH-1:0]  rd_start_addr,
  input  logic [BRAM_ADDR_WIDTH:0]    rd_length,
  output logic [31:0]                 rd_status,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        bram_portb_clk,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata,
  output logic                        bram_portb_en
);

  localparam int LW = BRAM_ADDR_WIDTH + 1;
  localparam logic [LW-1:0]              ONE_L = LW'(1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ONE_A = BRAM_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LW-1:0]              issue_cnt_q, issue_cnt_d;
  logic [LW-1:0]              send_cnt_q, send_cnt_d;
  logic [15:0]                sent_q, sent_d;
  logic                       dv_q;
  logic [1:0][BRAM_DATA_WIDTH-1:0] mem_q;
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 cnt_q;

  logic rd_enable, start, abort, pop, push, issue, last_issue, head_last, busy, done;
  logic [2:0] occ;
  logic [BRAM_DATA_WIDTH-1:0] head;
  logic unused_ctrl;

  assign rd_enable   = rd_control[0];
  assign unused_ctrl = ^rd_control[31:1];

  assign start     = (state_q == S_IDLE) && rd_enable;
  assign abort     = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !rd_enable;
  assign push      = dv_q;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign head      = mem_q[rd_ptr_q];
  assign head_last = m_axis_tvalid && (send_cnt_q == ONE_L);

  // Occupancy once this cycle's pop and the read already on the BRAM bus have landed;
  // a new read issued now lands one edge after that, so at most one slot may be used here.
  assign occ = {1'b0, cnt_q} + {2'b0, dv_q} - {2'b0, pop};

  // FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (rd_enable) state_d = (rd_length == '0) ? S_DONE : S_RUN;
      S_RUN:   if (!rd_enable) state_d = S_IDLE;
               else if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (!rd_enable) state_d = S_IDLE;
               else if (pop && head_last) state_d = S_DONE;
      S_DONE:  if (!rd_enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    done  = (state_q == S_DONE);
    issue = (state_q == S_RUN) && rd_enable && (issue_cnt_q != '0) && (occ < 3'd2);
  end

  assign last_issue = issue && (issue_cnt_q == ONE_L);

  always_comb begin
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    send_cnt_d  = send_cnt_q;
    sent_d      = sent_q;
    if (start) begin
      rd_addr_d   = rd_start_addr;
      issue_cnt_d = rd_length;
      send_cnt_d  = rd_length;
      sent_d      = '0;
    end else if (abort) begin
      issue_cnt_d = '0;
      send_cnt_d  = '0;
    end else begin
      if (issue) begin
        rd_addr_d   = rd_addr_q + ONE_A;
        issue_cnt_d = issue_cnt_q - ONE_L;
      end
      if (pop) begin
        send_cnt_d = send_cnt_q - ONE_L;
        sent_d     = sent_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
      sent_q      <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      send_cnt_q  <= send_cnt_d;
      sent_q      <= sent_d;
    end
  end

  // Output FIFO; an abort drops both the stored words and the read still on the bus.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dv_q     <= 1'b0;
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else if (abort) begin
      dv_q     <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      dv_q <= issue;
      if (push) begin
        mem_q[wr_ptr_q] <= bram_portb_rddata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign m_axis_tvalid   = (cnt_q != '0);
  assign m_axis_tdata    = {{(AXIS_TDATA_WIDTH-BRAM_DATA_WIDTH){head[BRAM_DATA_WIDTH-1]}}, head};
  assign m_axis_tlast    = head_last;
  assign bram_portb_clk  = aclk;
  assign bram_portb_addr = rd_addr_q;
  assign bram_portb_en   = issue;
  assign rd_status       = {sent_q, 14'd0, busy, done};

endmodule

// File: tb/tb_axis_bram_reader.sv
// Directed bench for axis_bram_reader: BRAM model on port B, beat/issue logger, and
// immediate-assertion checks against hand-derived values.
module tb_axis_bram_reader;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] rd_control;
  logic [15:0] rd_start_addr;
  logic [16:0] rd_length;
  logic [31:0] rd_status;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        bram_portb_clk, bram_portb_en;
  logic [15:0] bram_portb_addr;
  logic [15:0] bram_portb_rddata = '0;

  axis_bram_reader dut (
    .aclk(aclk), .aresetn(aresetn), .rd_control(rd_control),
    .rd_start_addr(rd_start_addr), .rd_length(rd_length), .rd_status(rd_status),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .bram_portb_clk(bram_portb_clk), .bram_portb_addr(bram_portb_addr),
    .bram_portb_rddata(bram_portb_rddata), .bram_portb_en(bram_portb_en)
  );

  always #5 aclk = ~aclk;

  logic [15:0] bram [0:65535];
  always @(posedge aclk) if (bram_portb_en) bram_portb_rddata <= bram[bram_portb_addr];

  // Logger: accepted beats, issued addresses, outstanding reads, stall stability.
  logic [31:0] beat_d[$];
  logic        beat_l[$];
  int          hs_cyc[$];
  logic [15:0] iss_a[$];
  int cyc = 0, iss_n = 0, hs_n = 0, max_out = 0, stall_viol = 0;
  bit chk_stall = 0;
  logic        p_valid = 0, p_ready = 0, p_last = 0;
  logic [31:0] p_data = '0;

  always @(posedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (bram_portb_en) begin iss_n++; iss_a.push_back(bram_portb_addr); end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_n++;
        beat_d.push_back(m_axis_tdata);
        beat_l.push_back(m_axis_tlast);
        hs_cyc.push_back(cyc);
      end
      if (iss_n - hs_n > max_out) max_out = iss_n - hs_n;
      if (chk_stall && p_valid && !p_ready &&
          (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_data || m_axis_tlast !== p_last))
        stall_viol++;
    end
    p_valid = m_axis_tvalid; p_ready = m_axis_tready;
    p_data  = m_axis_tdata;  p_last  = m_axis_tlast;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic clear_log();
    beat_d.delete(); beat_l.delete(); hs_cyc.delete(); iss_a.delete();
    iss_n = 0; hs_n = 0; max_out = 0; stall_viol = 0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (rd_status[0] !== 1'b1 && k < budget) begin step(); k++; end
    chk(tag, 32'(rd_status[0]), 32'd1);
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Runs a transfer at tready=1 and checks data/tlast against BRAM[a]=a.
  task automatic run_check(input string tag, input logic [15:0] sa, input int len);
    clear_log();
    rd_start_addr = sa; rd_length = 17'(len); m_axis_tready = 1'b1; rd_control = 32'd1;
    wait_done(len + 20, {tag, "_done"});
    chk({tag, "_nbeats"}, 32'(beat_d.size()), 32'(len));
    for (int i = 0; i < len && i < beat_d.size(); i++) begin
      chk({tag, "_data"}, beat_d[i], sx(16'(sa + 16'(i))));
      chk({tag, "_last"}, 32'(beat_l[i]), 32'(i == len - 1));
    end
    chk({tag, "_sent"}, 32'(rd_status[31:16]), 32'(len));
    rd_control = 32'd0;
    step();
    chk({tag, "_idle"}, 32'(rd_status[1:0]), 32'd0);
  endtask

  logic [0:31] pat;

  initial begin
    int k;
    for (int a = 0; a < 65536; a++) bram[a] = 16'(a);
    bram[16'h0010] = 16'h8001;
    aresetn = 1'b0; rd_control = '0; rd_start_addr = '0; rd_length = '0; m_axis_tready = 1'b0;
    @(negedge aclk); @(negedge aclk);
    chk("rst_status", rd_status, 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_en",     32'(bram_portb_en), 32'd0);
    chk("rst_tdata",  m_axis_tdata, 32'd0);
    aresetn = 1'b1;
    step();

    // Single word, negative sample
    clear_log();
    rd_start_addr = 16'h0010; rd_length = 17'd1; m_axis_tready = 1'b1; rd_control = 32'd1;
    wait_done(20, "single_done");
    chk("single_nbeats", 32'(beat_d.size()), 32'd1);
    if (beat_d.size() > 0) begin
      chk("single_data", beat_d[0], 32'hFFFF8001);
      chk("single_last", 32'(beat_l[0]), 32'd1);
    end
    chk("single_status", rd_status, 32'h0001_0001);
    rd_control = 32'd0;
    step();
    chk("single_idle", 32'(rd_status[1:0]), 32'd0);

    // Full rate: tvalid first visible after the third edge following enable
    clear_log();
    rd_start_addr = 16'h0100; rd_length = 17'd16; m_axis_tready = 1'b1; rd_control = 32'd1;
    step(); chk("lat_e1", 32'(m_axis_tvalid), 32'd0);
    chk("lat_busy", 32'(rd_status[1:0]), 32'd2);
    step(); chk("lat_e2", 32'(m_axis_tvalid), 32'd0);
    step(); chk("lat_e3", 32'(m_axis_tvalid), 32'd1);
    chk("lat_data0", m_axis_tdata, 32'h0000_0100);
    wait_done(40, "full_done");
    chk("full_nbeats", 32'(beat_d.size()), 32'd16);
    for (int i = 0; i < 16 && i < beat_d.size(); i++) begin
      chk("full_data", beat_d[i], 32'h100 + 32'(i));
      chk("full_last", 32'(beat_l[i]), 32'(i == 15));
    end
    if (hs_cyc.size() == 16) chk("full_nobubble", 32'(hs_cyc[15] - hs_cyc[0]), 32'd15);
    rd_control = 32'd0;
    step();

    // Address wrap
    run_check("wrap", 16'hFFFE, 4);
    chk("wrap_niss", 32'(iss_a.size()), 32'd4);
    if (iss_a.size() == 4) begin
      chk("wrap_a0", 32'(iss_a[0]), 32'h0000_FFFE);
      chk("wrap_a1", 32'(iss_a[1]), 32'h0000_FFFF);
      chk("wrap_a2", 32'(iss_a[2]), 32'h0000_0000);
      chk("wrap_a3", 32'(iss_a[3]), 32'h0000_0001);
    end

    // Backpressure, including five consecutive tready-low cycles
    clear_log();
    pat = 32'b1010_0000_1101_0111_0011_0101_1111_1111;
    chk_stall = 1;
    rd_start_addr = 16'h0200; rd_length = 17'd8; rd_control = 32'd1;
    k = 0;
    while (rd_status[0] !== 1'b1 && k < 200) begin
      m_axis_tready = pat[5'(k % 32)];
      step(); k++;
    end
    chk_stall = 0;
    chk("bp_done", 32'(rd_status[0]), 32'd1);
    chk("bp_nbeats", 32'(beat_d.size()), 32'd8);
    for (int i = 0; i < 8 && i < beat_d.size(); i++) begin
      chk("bp_data", beat_d[i], 32'h200 + 32'(i));
      chk("bp_last", 32'(beat_l[i]), 32'(i == 7));
    end
    chk("bp_stable", 32'(stall_viol), 32'd0);
    chk("bp_credit", 32'(max_out <= 2), 32'd1);
    chk("bp_sent", 32'(rd_status[31:16]), 32'd8);
    rd_control = 32'd0; m_axis_tready = 1'b1;
    step();

    // Zero length straight to DONE, then restart
    clear_log();
    rd_length = 17'd0; rd_start_addr = 16'h0300; rd_control = 32'd1;
    step();
    chk("zero_status", rd_status, 32'h0000_0001);
    step(); step(); step();
    chk("zero_nbeats", 32'(beat_d.size()), 32'd0);
    chk("zero_niss", 32'(iss_n), 32'd0);
    rd_control = 32'd0;
    step();
    chk("zero_idle", rd_status, 32'd0);
    run_check("restart", 16'h0300, 3);

    // Abort after five beats
    clear_log();
    rd_start_addr = 16'h0400; rd_length = 17'd20; m_axis_tready = 1'b1; rd_control = 32'd1;
    k = 0;
    while (beat_d.size() < 5 && k < 50) begin step(); k++; end
    chk("abort_five", 32'(beat_d.size()), 32'd5);
    rd_control = 32'd0; m_axis_tready = 1'b0;
    step();
    chk("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("abort_en", 32'(bram_portb_en), 32'd0);
    chk("abort_status", 32'(rd_status[1:0]), 32'd0);
    chk("abort_nbeats", 32'(beat_d.size()), 32'd5);
    chk("abort_notlast", 32'(beat_l.sum() with (int'(item))), 32'd0);
    run_check("post_abort", 16'h0000, 2);

    // Asynchronous reset mid-transfer
    clear_log();
    rd_start_addr = 16'h0500; rd_length = 17'd20; m_axis_tready = 1'b0; rd_control = 32'd1;
    step(); step(); step(); step();
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_tdata",  m_axis_tdata, 32'd0);
    chk("arst_tlast",  32'(m_axis_tlast), 32'd0);
    chk("arst_en",     32'(bram_portb_en), 32'd0);
    chk("arst_addr",   32'(bram_portb_addr), 32'd0);
    chk("arst_status", rd_status, 32'd0);
    rd_control = 32'd0;
    @(negedge aclk);
    aresetn = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
